// File: rtl/fir_pkg.sv
// Shared constants, FSM state type and default coefficient set for the fir_mac16 filter.
// The default coefficients are a 16-tap moving average. Each coefficient is 16, so the sum is 256 (unity gain in Q8).
package fir_pkg;

    localparam int TAPS       = 16;
    localparam int COEF_W     = 9;
    localparam int ADC_OFFSET = 512;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        ROUND
    } state_t;

    localparam logic [TAPS-1:0][COEF_W-1:0] DEFAULT_COEF = {TAPS{9'd16}};

endpackage

// File: rtl/fir_coef_rom.sv
// Combinational coefficient lookup for the serial MAC.
// A designed low-pass can replace this table without touching the datapath.
module fir_coef_rom #(
    parameter int TAPS   = 16,
    parameter int COEF_W = 9
) (
    input  logic [$clog2(TAPS)-1:0] k,
    output logic signed [COEF_W-1:0] coef
);

    always_comb begin
        coef = COEF_W'($signed(fir_pkg::DEFAULT_COEF[k]));
    end

endmodule

// File: rtl/fir_mac16.sv
// Serial-MAC FIR stage: one multiply-accumulate per clock over a circular history, then round and saturate.
// Optional macro FIR_MAC16_BYPASS_EN adds a bypass input that passes samples straight through.
module fir_mac16 #(
    parameter int TAPS   = fir_pkg::TAPS,
    parameter int COEF_W = fir_pkg::COEF_W,
    parameter int ACC_W  = 24
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic       data_valid,
    input  logic [9:0] data_in,
    output logic [9:0] data_out,
    output logic       out_valid,
    output logic       busy,
    output logic       overrun
`ifdef FIR_MAC16_BYPASS_EN
    ,
    input  logic       bypass
`endif
);
    import fir_pkg::*;

    localparam int PW   = $clog2(TAPS);
    localparam int PRDW = 11 + COEF_W;
    localparam logic [PW-1:0]           K_LAST   = PW'(TAPS - 1);
    localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(128);
    localparam logic signed [ACC_W-1:0] Y_MAX    = ACC_W'(511);
    localparam logic signed [ACC_W-1:0] Y_MIN    = -ACC_W'(512);

    state_t                  state_q, state_d;
    logic [PW-1:0]           wp_q, wp_d;
    logic [PW-1:0]           k_q, k_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [10:0]      hist_q [TAPS];
    logic signed [10:0]      hist_d [TAPS];
    logic [9:0]              data_out_q, data_out_d;
    logic                    out_valid_q, out_valid_d;
    logic                    overrun_q, overrun_d;

    logic                    bypass_act;
    logic signed [10:0]      s_in;
    logic [PW-1:0]           rd_idx;
    logic signed [COEF_W-1:0] coef_k;
    logic signed [PRDW-1:0]  prod;
    logic signed [ACC_W-1:0] rnd_sum;
    logic signed [ACC_W-1:0] y_full;
    logic signed [10:0]      y_sat;

`ifdef FIR_MAC16_BYPASS_EN
    assign bypass_act = bypass;
`else
    assign bypass_act = 1'b0;
`endif

    fir_coef_rom #(
        .TAPS   (TAPS),
        .COEF_W (COEF_W)
    ) u_coef_rom (
        .k    (k_q),
        .coef (coef_k)
    );

    // wp already points past the newest sample while in MAC, hence the extra -1.
    always_comb begin
        s_in    = $signed({1'b0, data_in}) - 11'sd512;
        rd_idx  = wp_q - PW'(1) - k_q;
        prod    = hist_q[rd_idx] * coef_k;
        rnd_sum = acc_q + RND_HALF;
        y_full  = rnd_sum >>> 8;
        if (y_full > Y_MAX) begin
            y_sat = 11'sd511;
        end else if (y_full < Y_MIN) begin
            y_sat = -11'sd512;
        end else begin
            y_sat = y_full[10:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        wp_d        = wp_q;
        k_d         = k_q;
        acc_d       = acc_q;
        hist_d      = hist_q;
        data_out_d  = data_out_q;
        out_valid_d = 1'b0;
        overrun_d   = overrun_q;

        case (state_q)
            IDLE: begin
                if (data_valid) begin
                    hist_d[wp_q] = s_in;
                    wp_d         = wp_q + PW'(1);
                    if (bypass_act) begin
                        data_out_d  = data_in;
                        out_valid_d = 1'b1;
                    end else begin
                        acc_d   = '0;
                        k_d     = '0;
                        state_d = MAC;
                    end
                end
            end
            MAC: begin
                acc_d = acc_q + ACC_W'(prod);
                k_d   = k_q + PW'(1);
                if (k_q == K_LAST) begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                data_out_d  = 10'(y_sat + 11'sd512);
                out_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (data_valid && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wp_q        <= '0;
            k_q         <= '0;
            acc_q       <= '0;
            hist_q      <= '{default: '0};
            data_out_q  <= 10'(ADC_OFFSET);
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wp_q        <= wp_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            hist_q      <= hist_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != IDLE);
    assign overrun   = overrun_q;

endmodule
